// File: rtl/serdes_tx_arbiter_if.sv
// rtl/serdes_tx_arbiter_if.sv - source/FIFO-write bundle for the TX arbiter
//
// Purpose: groups the per-source streaming inputs, the FIFO write port and the
// arbiter status outputs into one interface.
//   i_s_valid/i_s_data/i_s_last : per-source beat stream (driven by sources)
//   o_s_ready                   : per-source ready (driven by arbiter)
//   o_fifo_wr/o_fifo_wdata      : FIFO write port (driven by arbiter)
//   i_fifo_full                 : FIFO full flag (driven by FIFO)
//   o_busy/o_grant_id/o_trunc   : arbiter status
// Modports: slave = the arbiter, master = the surrounding environment.
interface serdes_tx_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]             i_s_valid;
  logic [NUM_SRC-1:0][DATA_W-1:0] i_s_data;
  logic [NUM_SRC-1:0]             i_s_last;
  logic [NUM_SRC-1:0]             o_s_ready;
  logic                           o_fifo_wr;
  logic [DATA_W-1:0]              o_fifo_wdata;
  logic                           i_fifo_full;
  logic                           o_busy;
  logic [ID_W-1:0]                o_grant_id;
  logic                           o_trunc;

  modport slave (
    input  i_s_valid, i_s_data, i_s_last, i_fifo_full,
    output o_s_ready, o_fifo_wr, o_fifo_wdata, o_busy, o_grant_id, o_trunc
  );

  modport master (
    output i_s_valid, i_s_data, i_s_last, i_fifo_full,
    input  o_s_ready, o_fifo_wr, o_fifo_wdata, o_busy, o_grant_id, o_trunc
  );
endinterface

// File: rtl/serdes_tx_arbiter.sv
// rtl/serdes_tx_arbiter.sv - round-robin packet-locked arbiter for the TX FIFO write port
//
// Purpose: shares the TX async FIFO write port among NUM_SRC streaming sources.
// Each granted packet is preceded by one header beat {1'b1, source id}; data
// beats then pass straight through under FIFO backpressure. Packets longer
// than MAX_BEATS are cut; the remainder re-arbitrates as a new packet.
// Ports:
//   i_clk : FIFO write clock
//   i_rst : asynchronous active-high reset
//   bus   : serdes_tx_arbiter_if.slave (source streams, FIFO write port, status)
module serdes_tx_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  serdes_tx_arbiter_if.slave   bus
);
  localparam int ID_W  = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_SRC - 1);

  if (NUM_SRC < 2) begin : g_chk_src
    $error("serdes_tx_arbiter: NUM_SRC must be >= 2");
  end
  if (DATA_W - 1 < ID_W) begin : g_chk_w
    $error("serdes_tx_arbiter: DATA_W too narrow for the source id");
  end
  if (MAX_BEATS < 1) begin : g_chk_max
    $error("serdes_tx_arbiter: MAX_BEATS must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Round-robin search: first valid source starting at rr_ptr, wrapping.
  logic            req_found;
  logic [ID_W-1:0] req_pick;
  logic [ID_W-1:0] req_cand;
  int              req_idx;

  always_comb begin
    req_found = 1'b0;
    req_pick  = rr_ptr_q;
    req_cand  = '0;
    req_idx   = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req_idx = int'(rr_ptr_q) + i;
      if (req_idx >= NUM_SRC) begin
        req_idx = req_idx - NUM_SRC;
      end
      req_cand = ID_W'(req_idx);
      if (!req_found && bus.i_s_valid[req_cand]) begin
        req_found = 1'b1;
        req_pick  = req_cand;
      end
    end
  end

  // Header payload: marker bit plus the zero-extended granted id.
  logic [DATA_W-2:0] hdr_id;
  always_comb begin
    hdr_id             = '0;
    hdr_id[ID_W-1:0]   = grant_q;
  end

  logic               s_ready;
  logic [NUM_SRC-1:0] s_ready_vec;
  logic               fifo_wr;
  logic [DATA_W-1:0]  fifo_wdata;
  logic               trunc;
  logic               xfer;
  logic               cap_hit;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    s_ready     = 1'b0;
    s_ready_vec = '0;
    fifo_wr     = 1'b0;
    fifo_wdata  = '0;
    trunc       = 1'b0;
    // Only meaningful in DATA; the granted source's beat moves this cycle.
    xfer        = bus.i_s_valid[grant_q] & ~bus.i_fifo_full;
    cap_hit     = (beat_cnt_q == LAST_CNT);

    case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          grant_d    = req_pick;
          beat_cnt_d = '0;
          state_d    = ST_HDR;
        end
      end

      ST_HDR: begin
        fifo_wr    = ~bus.i_fifo_full;
        fifo_wdata = {1'b1, hdr_id};
        if (!bus.i_fifo_full) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        s_ready              = ~bus.i_fifo_full;
        s_ready_vec[grant_q] = s_ready;
        fifo_wr              = xfer;
        fifo_wdata           = bus.i_s_data[grant_q];
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (bus.i_s_last[grant_q] || cap_hit) begin
            // Cut at the length cap: remaining beats come back as a new packet.
            trunc    = ~bus.i_s_last[grant_q];
            rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);
            state_d  = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // All outputs decode from state, so an async reset zeroes them immediately.
  assign bus.o_s_ready    = s_ready_vec;
  assign bus.o_fifo_wr    = fifo_wr;
  assign bus.o_fifo_wdata = fifo_wdata;
  assign bus.o_busy       = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign bus.o_grant_id   = grant_q;
  assign bus.o_trunc      = trunc;
endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// tb/tb_serdes_tx_arbiter.sv - self-checking bench for serdes_tx_arbiter
module tb_serdes_tx_arbiter;
  localparam int NS     = 4;
  localparam int DW     = 8;
  localparam int MB     = 16;
  localparam int MAXLEN = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serdes_tx_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) bus ();

  serdes_tx_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  logic [7:0] dmem [NS][MAXLEN];
  bit         lmem [NS][MAXLEN];
  int         len  [NS];
  int         pos  [NS];
  int         seg  [NS];
  bit         force_off [NS];
  int         gap_pct;

  logic [7:0] cap_q[$];
  int         cap_cyc[$];
  int         cyc;
  int         wr_full_err, rdy_full_err, rdy_multi_err, trunc_cnt, trunc_at_beat;

  logic [7:0] exp_q[$];
  int         exp_trunc;
  int         model_rr;
  int         first_bad;

  task automatic clear_sources();
    for (int s = 0; s < NS; s++) begin
      len[s] = 0; pos[s] = 0; seg[s] = 0; force_off[s] = 1'b0;
    end
    cap_q.delete(); cap_cyc.delete();
    cyc = 0; wr_full_err = 0; rdy_full_err = 0; rdy_multi_err = 0;
    trunc_cnt = 0; trunc_at_beat = -1;
  endtask

  task automatic add_packet(input int s, input int n, input bit fixed, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      dmem[s][len[s]+k] = fixed ? base + 8'(k) : 8'($urandom);
      lmem[s][len[s]+k] = (k == n - 1);
    end
    len[s] = len[s] + n;
  endtask

  function automatic bit all_done();
    for (int s = 0; s < NS; s++) if (pos[s] < len[s]) return 1'b0;
    return 1'b1;
  endfunction

  // Packet-level reference: who gets served, in what order, with which bytes.
  function automatic void build_model();
    int p [NS];
    int rr, s, n;
    bit lb;
    exp_q.delete();
    exp_trunc = 0;
    rr = model_rr;
    for (int i = 0; i < NS; i++) p[i] = 0;
    while (1) begin
      s = -1;
      for (int k = 0; k < NS; k++)
        if (s < 0 && p[(rr + k) % NS] < len[(rr + k) % NS]) s = (rr + k) % NS;
      if (s < 0) break;
      exp_q.push_back(8'h80 | 8'(s));
      n = 0;
      while (1) begin
        exp_q.push_back(dmem[s][p[s]]);
        lb = lmem[s][p[s]];
        p[s]++;
        n++;
        if (lb) break;
        if (n == MB) begin
          exp_trunc++;
          break;
        end
      end
      rr = (s + 1) % NS;
    end
    model_rr = rr;
  endfunction

  function automatic int stream_bad();
    int bad = 0;
    first_bad = -1;
    if (cap_q.size() != exp_q.size()) bad++;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    return bad;
  endfunction

  // One clock: drive sources at negedge, sample combinational outputs before posedge.
  task automatic tick(input bit full);
    logic [NS-1:0]         v, l;
    logic [NS-1:0][DW-1:0] d;
    @(negedge clk);
    v = '0; l = '0; d = '0;
    for (int s = 0; s < NS; s++) begin
      if (pos[s] < len[s]) begin
        v[s] = !force_off[s] && !(seg[s] > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct);
        d[s] = dmem[s][pos[s]];
        l[s] = lmem[s][pos[s]];
      end
    end
    bus.i_s_valid = v; bus.i_s_data = d; bus.i_s_last = l; bus.i_fifo_full = full;
    #2;
    if (bus.o_fifo_wr) begin
      cap_q.push_back(bus.o_fifo_wdata);
      cap_cyc.push_back(cyc);
      if (full) wr_full_err++;
    end
    if (full && bus.o_s_ready != '0) rdy_full_err++;
    if ($countones(bus.o_s_ready) > 1) rdy_multi_err++;
    for (int s = 0; s < NS; s++) begin
      if (v[s] && bus.o_s_ready[s]) begin
        pos[s]++;
        if (l[s] || seg[s] + 1 == MB) seg[s] = 0; else seg[s]++;
        if (bus.o_trunc) trunc_at_beat = pos[s];
      end
    end
    if (bus.o_trunc) trunc_cnt++;
    cyc++;
  endtask

  task automatic run_to_done(input int budget, input int full_pct, output bit timed_out);
    int c = 0;
    while (!all_done() && c < budget) begin
      tick(full_pct > 0 && $urandom_range(99) < full_pct);
      c++;
    end
    timed_out = !all_done();
    tick(1'b0);
    tick(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_s_valid = '0; bus.i_s_data = '0; bus.i_s_last = '0; bus.i_fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_sources();
    model_rr = 0;
    gap_pct  = 0;
  endtask

  task automatic test_reset();
    bus.i_s_valid = '1; bus.i_s_data = '1; bus.i_s_last = '0; bus.i_fifo_full = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (bus.o_s_ready !== 4'h0) $display("FAIL rst_ready: got %h required 0", bus.o_s_ready); else passed++;
    total++; if (bus.o_fifo_wr !== 1'b0) $display("FAIL rst_wr: got %b required 0", bus.o_fifo_wr); else passed++;
    total++; if (bus.o_fifo_wdata !== 8'h00) $display("FAIL rst_wdata: got %h required 00", bus.o_fifo_wdata); else passed++;
    total++; if (bus.o_busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", bus.o_busy); else passed++;
    total++; if (bus.o_grant_id !== 2'd0) $display("FAIL rst_grant: got %0d required 0", bus.o_grant_id); else passed++;
    total++; if (bus.o_trunc !== 1'b0) $display("FAIL rst_trunc: got %b required 0", bus.o_trunc); else passed++;
    do_reset();
  endtask

  task automatic test_single();
    bit to;
    int nb;
    do_reset();
    add_packet(2, 3, 1'b1, 8'hA1);
    build_model();
    run_to_done(50, 0, to);
    total++; if (to) $display("FAIL single_timeout: got timeout required completion"); else passed++;
    nb = stream_bad();
    total++;
    if (nb !== 0) $display("FAIL single_stream: %0d bad, got %0d bytes required %0d, first bad idx %0d", nb, cap_q.size(), exp_q.size(), first_bad);
    else passed++;
    total++;
    if (cap_q.size() != 4 || cap_q[0] !== 8'h82 || cap_q[3] !== 8'hA3)
      $display("FAIL single_bytes: got %0d bytes required 82 A1 A2 A3", cap_q.size());
    else passed++;
    total++;
    if (cap_cyc.size() != 4 || cap_cyc[0] != 1 || cap_cyc[3] != 4)
      $display("FAIL single_timing: got %0d writes required 4 writes at cycles 1..4", cap_cyc.size());
    else passed++;
    total++; if (bus.o_grant_id !== 2'd2) $display("FAIL single_grant: got %0d required 2", bus.o_grant_id); else passed++;
    total++; if (bus.o_busy !== 1'b0) $display("FAIL single_busy_after: got %b required 0", bus.o_busy); else passed++;
  endtask

  task automatic test_round_robin();
    bit to;
    int nb, bad_gap;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NS; s++) add_packet(s, 1, 1'b0, 8'h00);
    build_model();
    run_to_done(100, 0, to);
    total++; if (to) $display("FAIL rr_timeout: got timeout required completion"); else passed++;
    nb = stream_bad();
    total++;
    if (nb !== 0) $display("FAIL rr_stream: %0d bad, got %0d bytes required %0d, first bad idx %0d", nb, cap_q.size(), exp_q.size(), first_bad);
    else passed++;
    total++;
    if (cap_q.size() != 16 || cap_q[0] !== 8'h80 || cap_q[6] !== 8'h83 || cap_q[8] !== 8'h80)
      $display("FAIL rr_order: got %0d bytes required header order 80 81 82 83 80", cap_q.size());
    else passed++;
    bad_gap = 0;
    if (cap_cyc.size() == 16) begin
      for (int k = 0; k < 7; k++) if (cap_cyc[2*k+2] - cap_cyc[2*k] != 3) bad_gap++;
    end else bad_gap = 99;
    total++; if (bad_gap != 0) $display("FAIL rr_spacing: got %0d bad gaps required 0 (3 cycles/packet)", bad_gap); else passed++;
  endtask

  task automatic test_backpressure();
    bit to, full;
    int nb;
    do_reset();
    add_packet(1, 6, 1'b0, 8'h00);
    build_model();
    for (int t = 0; t < 14; t++) begin
      full = (t >= 1 && t <= 5) || t == 9 || t == 10;
      tick(full);
      if (t == 3) begin
        total++;
        if (bus.o_busy !== 1'b1 || bus.o_fifo_wr !== 1'b0)
          $display("FAIL bp_hdr_hold: got busy=%b wr=%b required busy=1 wr=0", bus.o_busy, bus.o_fifo_wr);
        else passed++;
      end
    end
    run_to_done(50, 0, to);
    total++; if (to) $display("FAIL bp_timeout: got timeout required completion"); else passed++;
    total++; if (wr_full_err != 0) $display("FAIL bp_wr_full: got %0d writes while full required 0", wr_full_err); else passed++;
    total++; if (rdy_full_err != 0) $display("FAIL bp_ready_full: got %0d ready while full required 0", rdy_full_err); else passed++;
    nb = stream_bad();
    total++;
    if (nb !== 0) $display("FAIL bp_stream: %0d bad, got %0d bytes required %0d, first bad idx %0d", nb, cap_q.size(), exp_q.size(), first_bad);
    else passed++;
  endtask

  task automatic test_truncation();
    bit to;
    int nb;
    do_reset();
    add_packet(1, 20, 1'b1, 8'h10);
    build_model();
    run_to_done(100, 0, to);
    total++; if (to) $display("FAIL trunc_timeout: got timeout required completion"); else passed++;
    nb = stream_bad();
    total++;
    if (nb !== 0) $display("FAIL trunc_stream: %0d bad, got %0d bytes required %0d, first bad idx %0d", nb, cap_q.size(), exp_q.size(), first_bad);
    else passed++;
    total++; if (trunc_cnt != exp_trunc) $display("FAIL trunc_count: got %0d required %0d", trunc_cnt, exp_trunc); else passed++;
    total++; if (trunc_at_beat != MB) $display("FAIL trunc_beat: got %0d required %0d", trunc_at_beat, MB); else passed++;
    total++;
    if (cap_q.size() != 22 || cap_q[17] !== 8'h81)
      $display("FAIL trunc_rehdr: got %0d bytes required 22 with 81 at index 17", cap_q.size());
    else passed++;
  endtask

  task automatic test_lock_stall();
    bit to;
    int nb, c, bad, wr_before;
    do_reset();
    add_packet(0, 4, 1'b1, 8'h40);
    add_packet(3, 2, 1'b1, 8'h30);
    build_model();
    c = 0;
    while (pos[0] < 2 && c < 20) begin tick(1'b0); c++; end
    total++; if (pos[0] < 2) $display("FAIL lock_start: got %0d beats required 2", pos[0]); else passed++;
    force_off[0] = 1'b1;
    bad = 0;
    wr_before = cap_q.size();
    for (int t = 0; t < 10; t++) begin
      tick(1'b0);
      if (bus.o_grant_id !== 2'd0 || bus.o_s_ready[3] !== 1'b0 || bus.o_busy !== 1'b1) bad++;
    end
    total++; if (bad != 0) $display("FAIL lock_hold: got %0d bad stall cycles required 0", bad); else passed++;
    total++; if (cap_q.size() != wr_before) $display("FAIL lock_nowrite: got %0d writes during stall required 0", cap_q.size() - wr_before); else passed++;
    force_off[0] = 1'b0;
    run_to_done(50, 0, to);
    total++; if (to) $display("FAIL lock_timeout: got timeout required completion"); else passed++;
    nb = stream_bad();
    total++;
    if (nb !== 0) $display("FAIL lock_stream: %0d bad, got %0d bytes required %0d, first bad idx %0d", nb, cap_q.size(), exp_q.size(), first_bad);
    else passed++;
  endtask

  task automatic test_async_reset();
    bit to;
    int nb, c;
    do_reset();
    for (int s = 0; s < NS; s++) add_packet(s, 5, 1'b0, 8'h00);
    c = 0;
    while (pos[0] < 2 && c < 20) begin tick(1'b0); c++; end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (bus.o_s_ready !== 4'h0 || bus.o_fifo_wr !== 1'b0 || bus.o_busy !== 1'b0 ||
        bus.o_grant_id !== 2'd0 || bus.o_trunc !== 1'b0 || bus.o_fifo_wdata !== 8'h00)
      $display("FAIL arst_outputs: got rdy=%h wr=%b busy=%b gid=%0d trunc=%b wdata=%h required all 0",
               bus.o_s_ready, bus.o_fifo_wr, bus.o_busy, bus.o_grant_id, bus.o_trunc, bus.o_fifo_wdata);
    else passed++;
    @(negedge clk);
    total++; if (bus.o_fifo_wr !== 1'b0) $display("FAIL arst_hold_wr: got %b required 0", bus.o_fifo_wr); else passed++;
    bus.i_s_valid = '0; bus.i_s_data = '0; bus.i_s_last = '0;
    @(negedge clk);
    rst = 1'b0;
    clear_sources();
    model_rr = 0;
    for (int s = 0; s < NS; s++) add_packet(s, 1, 1'b0, 8'h00);
    build_model();
    run_to_done(60, 0, to);
    total++; if (to) $display("FAIL arst_timeout: got timeout required completion"); else passed++;
    total++;
    if (cap_q.size() == 0 || cap_q[0] !== 8'h80) $display("FAIL arst_first: got %0d bytes required first header 80", cap_q.size());
    else passed++;
    nb = stream_bad();
    total++;
    if (nb !== 0) $display("FAIL arst_stream: %0d bad, got %0d bytes required %0d, first bad idx %0d", nb, cap_q.size(), exp_q.size(), first_bad);
    else passed++;
  endtask

  task automatic test_random();
    bit to;
    int nb;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      clear_sources();
      gap_pct = 30;
      for (int s = 0; s < NS; s++) begin
        int np = $urandom_range(3);
        for (int p = 0; p < np; p++) add_packet(s, $urandom_range(24, 1), 1'b0, 8'h00);
      end
      build_model();
      run_to_done(3000, 30, to);
      total++; if (to) $display("FAIL rand%0d_timeout: got timeout required completion", r); else passed++;
      nb = stream_bad();
      total++;
      if (nb !== 0) $display("FAIL rand%0d_stream: %0d bad, got %0d bytes required %0d, first bad idx %0d", r, nb, cap_q.size(), exp_q.size(), first_bad);
      else passed++;
      total++; if (trunc_cnt != exp_trunc) $display("FAIL rand%0d_trunc: got %0d required %0d", r, trunc_cnt, exp_trunc); else passed++;
      total++;
      if (wr_full_err + rdy_full_err + rdy_multi_err != 0)
        $display("FAIL rand%0d_protocol: got wr_full=%0d rdy_full=%0d rdy_multi=%0d required 0", r, wr_full_err, rdy_full_err, rdy_multi_err);
      else passed++;
    end
    gap_pct = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_sources();
    gap_pct  = 0;
    model_rr = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_lock_stall();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
